// File: rtl/goldschmidt_ctrl.sv
// -----------------------------------------------------------------------------
// goldschmidt_ctrl
//
// Control sequencer for the Goldschmidt divider datapath. A single start
// request runs the whole divide: the operands are loaded, the initial
// approximation is applied to N and then D, ITER refinement pairs follow,
// and finally the N register is captured as the quotient. A zero divisor
// is caught when start is sampled, and the datapath is not run.
//
// Handshake (start/done):
//   start is sampled only while the FSM is IDLE. If it is high on a rising
//   edge in IDLE, the request is accepted on that edge. There is no queuing.
//   From the next cycle, busy stays high up to and including the done cycle.
//   done is a one-cycle pulse, issued in DONE (normal end) or ZERR (divide by
//   zero). A start that is held high is accepted again in the first IDLE
//   cycle after done.
//
// Ports:
//   clk, reset           rising-edge clock, synchronous active-high reset
//   start, d_in          request and divisor (d_in only feeds the zero check)
//   busy, done           operation in flight / completion pulse
//   div_zero             sticky error flag, cleared by the next accepted start
//   load_regN/D/K/Q      datapath register load strobes
//   sel_ND_mux           00 ext N/D, 01 D register, 10 N register
//   sel_K_mux            0 initial approximation, 1 K register
//   iter_count           refinement iterations completed in this operation
//
// Every control output is decoded from registered state only. No output has
// a combinational path from start or d_in.
// -----------------------------------------------------------------------------
module goldschmidt_ctrl #(
  parameter int ITER  = 3,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [15:0]      d_in,
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic             load_regN,
  output logic             load_regD,
  output logic             load_regK,
  output logic             load_regQ,
  output logic [1:0]       sel_ND_mux,
  output logic             sel_K_mux,
  output logic [CNT_W-1:0] iter_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_INIT_N = 3'd2,
    S_INIT_D = 3'd3,
    S_ITER_N = 3'd4,
    S_ITER_D = 3'd5,
    S_DONE   = 3'd6,
    S_ZERR   = 3'd7
  } state_t;

  localparam logic [CNT_W-1:0] ITER_LAST = CNT_W'(ITER);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] iter_q, iter_d;
  logic             dz_q, dz_d;
  logic [CNT_W-1:0] iter_inc;

  assign iter_inc = iter_q + CNT_W'(1);

  // State, counter and error flag registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      iter_q  <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      dz_q    <= dz_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    dz_d    = dz_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          iter_d = '0;
          if (d_in == 16'h0000) begin
            state_d = S_ZERR;
            dz_d    = 1'b1;
          end else begin
            state_d = S_LOAD;
            dz_d    = 1'b0;
          end
        end
      end
      S_LOAD:   state_d = S_INIT_N;
      S_INIT_N: state_d = S_INIT_D;
      S_INIT_D: state_d = S_ITER_N;
      // N is multiplied before D in every pair, so both see the same K;
      // K is reloaded from the new D in the D step of the pair.
      S_ITER_N: state_d = S_ITER_D;
      S_ITER_D: begin
        iter_d  = iter_inc;
        state_d = (iter_inc == ITER_LAST) ? S_DONE : S_ITER_N;
      end
      S_DONE:   state_d = S_IDLE;
      S_ZERR:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Moore output decode
  always_comb begin
    busy       = (state_q != S_IDLE);
    done       = 1'b0;
    load_regN  = 1'b0;
    load_regD  = 1'b0;
    load_regK  = 1'b0;
    load_regQ  = 1'b0;
    sel_ND_mux = 2'b00;
    sel_K_mux  = 1'b0;
    case (state_q)
      S_LOAD: begin
        load_regN = 1'b1;
        load_regD = 1'b1;
      end
      S_INIT_N: begin
        sel_ND_mux = 2'b10;
        load_regN  = 1'b1;
      end
      S_INIT_D: begin
        sel_ND_mux = 2'b01;
        load_regD  = 1'b1;
        load_regK  = 1'b1;
      end
      S_ITER_N: begin
        sel_ND_mux = 2'b10;
        sel_K_mux  = 1'b1;
        load_regN  = 1'b1;
      end
      S_ITER_D: begin
        sel_ND_mux = 2'b01;
        sel_K_mux  = 1'b1;
        load_regD  = 1'b1;
        load_regK  = 1'b1;
      end
      S_DONE: begin
        load_regQ = 1'b1;
        done      = 1'b1;
      end
      S_ZERR:  done = 1'b1;
      default: ;
    endcase
  end

  assign div_zero   = dz_q;
  assign iter_count = iter_q;

endmodule

// File: tb/tb_goldschmidt_ctrl.sv
module tb_goldschmidt_ctrl;

  // Clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset;
  logic        start;
  logic [15:0] d_in;

  // Three instances: index 0 ITER=3, index 1 ITER=1, index 2 ITER=7
  logic       busy_w[3];
  logic       done_w[3];
  logic       dz_w[3];
  logic       ldn_w[3];
  logic       ldd_w[3];
  logic       ldk_w[3];
  logic       ldq_w[3];
  logic [1:0] selnd_w[3];
  logic       selk_w[3];
  logic [2:0] iter_w[3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int IT = (g == 0) ? 3 : ((g == 1) ? 1 : 7);
    goldschmidt_ctrl #(.ITER(IT), .CNT_W(3)) dut (
      .clk        (clk),
      .reset      (reset),
      .start      (start),
      .d_in       (d_in),
      .busy       (busy_w[g]),
      .done       (done_w[g]),
      .div_zero   (dz_w[g]),
      .load_regN  (ldn_w[g]),
      .load_regD  (ldd_w[g]),
      .load_regK  (ldk_w[g]),
      .load_regQ  (ldq_w[g]),
      .sel_ND_mux (selnd_w[g]),
      .sel_K_mux  (selk_w[g]),
      .iter_count (iter_w[g])
    );
  end

  // Observed vector of the ITER=3 instance:
  // {busy, done, div_zero, ldN, ldD, ldK, ldQ, sel_ND[1:0], sel_K, iter[2:0]}
  logic [12:0] obs;
  assign obs = {busy_w[0], done_w[0], dz_w[0], ldn_w[0], ldd_w[0], ldk_w[0],
                ldq_w[0], selnd_w[0], selk_w[0], iter_w[0]};

  localparam int IDLE = 0, LOAD = 1, INIT_N = 2, INIT_D = 3,
                 ITER_N = 4, ITER_D = 5, DONE = 6, ZERR = 7;

  // Hand-written expected outputs per state
  function automatic logic [12:0] ex(input int s, input logic dz, input logic [2:0] it);
    logic [12:0] v;
    case (s)
      LOAD:    v = {1'b1, 1'b0, dz, 4'b1100, 2'b00, 1'b0, it};
      INIT_N:  v = {1'b1, 1'b0, dz, 4'b1000, 2'b10, 1'b0, it};
      INIT_D:  v = {1'b1, 1'b0, dz, 4'b0110, 2'b01, 1'b0, it};
      ITER_N:  v = {1'b1, 1'b0, dz, 4'b1000, 2'b10, 1'b1, it};
      ITER_D:  v = {1'b1, 1'b0, dz, 4'b0110, 2'b01, 1'b1, it};
      DONE:    v = {1'b1, 1'b1, dz, 4'b0001, 2'b00, 1'b0, it};
      ZERR:    v = {1'b1, 1'b1, dz, 4'b0000, 2'b00, 1'b0, it};
      default: v = {1'b0, 1'b0, dz, 4'b0000, 2'b00, 1'b0, it};
    endcase
    return v;
  endfunction

  // Vector table: inputs applied, then outputs sampled 1 time unit after the edge
  typedef struct {
    logic        start;
    logic [15:0] d;
    logic [12:0] exp;
  } vec_t;

  vec_t tbl[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic check(input string name, input int cyc, input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic s, input logic [15:0] d, input int st,
                     input logic dz, input logic [2:0] it);
    vec_t v;
    v.start = s;
    v.d     = d;
    v.exp   = ex(st, dz, it);
    tbl.push_back(v);
  endtask

  // One full ITER=3 operation; start is also pulsed on rows pa and pb
  task automatic add_op(input int pa, input int pb);
    int  seq[10];
    int  its[10];
    seq = '{LOAD, INIT_N, INIT_D, ITER_N, ITER_D, ITER_N, ITER_D, ITER_N, ITER_D, DONE};
    its = '{0, 0, 0, 0, 0, 1, 1, 2, 2, 3};
    for (int r = 0; r < 10; r++)
      add((r == 0) || (r == pa) || (r == pb), 16'h0060, seq[r], 1'b0, 3'(its[r]));
  endtask

  task automatic run_table(input string name);
    for (int i = 0; i < tbl.size(); i++) begin
      start = tbl[i].start;
      d_in  = tbl[i].d;
      step();
      check(name, i, 32'(obs), 32'(tbl[i].exp));
    end
    start = 1'b0;
    tbl.delete();
  endtask

  task automatic do_reset();
    reset = 1'b1;
    start = 1'b0;
    step();
    reset = 1'b0;
  endtask

  int first_done[3];
  int n_done[3];
  int n_pairs[3];
  int exp_lat[3]   = '{10, 6, 18};
  int exp_pairs[3] = '{3, 1, 7};

  initial begin
    // Reset held 2 cycles with start high
    reset = 1'b1;
    start = 1'b1;
    d_in  = 16'h0060;
    for (int i = 0; i < 2; i++) begin
      step();
      check("reset_idle", i, 32'(obs), 32'(ex(IDLE, 1'b0, 3'd0)));
    end
    reset = 1'b0;
    start = 1'b0;
    step();
    check("post_reset_idle", 0, 32'(obs), 32'(ex(IDLE, 1'b0, 3'd0)));

    // Nominal operation; iter_count holds 3 afterwards
    add_op(-1, -1);
    add(1'b0, 16'h0060, IDLE, 1'b0, 3'd3);
    add(1'b0, 16'h0060, IDLE, 1'b0, 3'd3);
    run_table("nominal");
    do_reset();

    // Start pulsed while busy, start during DONE ignored, held start re-accepted
    add_op(2, 6);
    add(1'b1, 16'h0060, IDLE, 1'b0, 3'd3);
    add(1'b1, 16'h0060, LOAD, 1'b0, 3'd0);
    add(1'b0, 16'h0060, INIT_N, 1'b0, 3'd0);
    run_table("start_busy");
    do_reset();

    // Divide by zero, sticky flag, cleared by the next accepted start
    add(1'b1, 16'h0000, ZERR, 1'b1, 3'd0);
    add(1'b0, 16'h0000, IDLE, 1'b1, 3'd0);
    add(1'b0, 16'h0060, IDLE, 1'b1, 3'd0);
    add(1'b1, 16'h0060, LOAD, 1'b0, 3'd0);
    add(1'b0, 16'h0060, INIT_N, 1'b0, 3'd0);
    run_table("div_zero");
    do_reset();

    // Reset during the second ITER_D aborts with no capture and no done
    add_op(-1, -1);
    tbl = tbl[0:6];
    run_table("pre_abort");
    reset = 1'b1;
    step();
    check("abort_idle", 0, 32'(obs), 32'(ex(IDLE, 1'b0, 3'd0)));
    reset = 1'b0;
    for (int i = 1; i < 5; i++) begin
      step();
      check("abort_quiet", i, 32'(obs), 32'(ex(IDLE, 1'b0, 3'd0)));
    end

    // Latency and pair count for ITER = 3, 1, 7
    do_reset();
    for (int g = 0; g < 3; g++) begin
      first_done[g] = 0;
      n_done[g]     = 0;
      n_pairs[g]    = 0;
    end
    start = 1'b1;
    d_in  = 16'h0060;
    for (int c = 1; c <= 25; c++) begin
      step();
      start = 1'b0;
      for (int g = 0; g < 3; g++) begin
        if (done_w[g]) begin
          n_done[g]++;
          if (first_done[g] == 0) first_done[g] = c;
        end
        if (ldn_w[g] && selk_w[g] && (selnd_w[g] == 2'b10)) n_pairs[g]++;
      end
    end
    for (int g = 0; g < 3; g++) begin
      check("sweep_latency", g, 32'(first_done[g]), 32'(exp_lat[g]));
      check("sweep_pairs", g, 32'(n_pairs[g]), 32'(exp_pairs[g]));
      check("sweep_done_cnt", g, 32'(n_done[g]), 32'd1);
      check("sweep_iter", g, 32'(iter_w[g]), 32'(exp_pairs[g]));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
